// File: rtl/uart_frame_decoder.sv
// uart_frame_decoder: turns 7-byte UART command frames into register requests and returns read data as 4 TX bytes
module uart_frame_decoder #(
    parameter logic [7:0] HEADER         = 8'h01,
    parameter logic [7:0] CMD_READ       = 8'h02,
    parameter logic [7:0] CMD_WRITE      = 8'h03,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        RX_EMPTY_I,
    output logic        RE_O,
    input  logic [7:0]  DREC_I,
    input  logic        TX_READY_I,
    output logic        WE_O,
    output logic [7:0]  DSEND_O,
    output logic        REQ_VALID_O,
    input  logic        REQ_READY_I,
    output logic        REQ_WRITE_O,
    output logic [7:0]  REQ_ADDR_O,
    output logic [31:0] REQ_DATA_O,
    input  logic        RSP_VALID_I,
    output logic        RSP_READY_O,
    input  logic [31:0] RSP_DATA_I,
    output logic        ERR_O,
    output logic        BUSY_O
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {IDLE, RX_CMD, RX_ADDR, RX_DATA, REQ, WAIT_RSP, TX} state_t;

    state_t        state_q, state_d;
    logic [7:0]    cmd_q, cmd_d, addr_q, addr_d;
    logic [31:0]   data_q, data_d, rsp_q, rsp_d;
    logic [1:0]    k_q, k_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
    logic          cmd_ok;

    assign cmd_ok      = cmd_q == CMD_READ || cmd_q == CMD_WRITE;
    assign RE_O        = (state_q inside {IDLE, RX_CMD, RX_ADDR, RX_DATA}) && !RX_EMPTY_I;
    assign WE_O        = state_q == TX && TX_READY_I;
    assign DSEND_O     = state_q == TX ? rsp_q[{k_q, 3'b000} +: 8] : 8'h00;
    assign REQ_VALID_O = state_q == REQ;
    assign REQ_WRITE_O = cmd_q == CMD_WRITE;
    assign REQ_ADDR_O  = addr_q;
    assign REQ_DATA_O  = data_q;
    assign RSP_READY_O = state_q == WAIT_RSP;
    assign ERR_O       = err_q;
    assign BUSY_O      = state_q != IDLE;

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rsp_d   = rsp_q;
        k_d     = k_q;
        tmo_d   = '0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (RE_O && DREC_I == HEADER) state_d = RX_CMD;
            RX_CMD, RX_ADDR, RX_DATA: begin
                if (RE_O) begin
                    if (state_q == RX_CMD) begin
                        cmd_d   = DREC_I;
                        state_d = RX_ADDR;
                    end else if (state_q == RX_ADDR) begin
                        addr_d  = DREC_I;
                        k_d     = 2'd0;
                        state_d = RX_DATA;
                    end else begin
                        data_d[{k_q, 3'b000} +: 8] = DREC_I;
                        k_d = k_q + 2'd1;
                        if (k_q == 2'd3) begin
                            state_d = cmd_ok ? REQ : IDLE;
                            err_d   = !cmd_ok;
                        end
                    end
                // inter-byte silence too long: drop the partial frame
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            REQ: if (REQ_READY_I) state_d = REQ_WRITE_O ? IDLE : WAIT_RSP;
            WAIT_RSP: if (RSP_VALID_I) begin
                rsp_d   = RSP_DATA_I;
                k_d     = 2'd0;
                state_d = TX;
            end
            TX: if (TX_READY_I) begin
                k_d = k_q + 2'd1;
                if (k_q == 2'd3) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            rsp_q   <= '0;
            k_q     <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rsp_q   <= rsp_d;
            k_q     <= k_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_uart_frame_decoder.sv
// tb_uart_frame_decoder: frame-level scoreboard bench with FIFO/responder models around uart_frame_decoder
module tb_uart_frame_decoder;
    localparam logic [7:0] HDR = 8'h01, RD = 8'h02, WR = 8'h03;

    logic        CLK_I = 1'b0, RST_I = 1'b1, RX_EMPTY_I = 1'b1, RE_O;
    logic [7:0]  DREC_I = 8'h00;
    logic        TX_READY_I = 1'b1, WE_O;
    logic [7:0]  DSEND_O;
    logic        REQ_VALID_O, REQ_READY_I = 1'b1, REQ_WRITE_O;
    logic [7:0]  REQ_ADDR_O;
    logic [31:0] REQ_DATA_O;
    logic        RSP_VALID_I = 1'b0, RSP_READY_O;
    logic [31:0] RSP_DATA_I = 32'h0;
    logic        ERR_O, BUSY_O;

    uart_frame_decoder #(.TIMEOUT_CYCLES(16)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .RX_EMPTY_I(RX_EMPTY_I), .RE_O(RE_O), .DREC_I(DREC_I),
        .TX_READY_I(TX_READY_I), .WE_O(WE_O), .DSEND_O(DSEND_O),
        .REQ_VALID_O(REQ_VALID_O), .REQ_READY_I(REQ_READY_I), .REQ_WRITE_O(REQ_WRITE_O),
        .REQ_ADDR_O(REQ_ADDR_O), .REQ_DATA_O(REQ_DATA_O),
        .RSP_VALID_I(RSP_VALID_I), .RSP_READY_O(RSP_READY_O), .RSP_DATA_I(RSP_DATA_I),
        .ERR_O(ERR_O), .BUSY_O(BUSY_O)
    );

    always #5 CLK_I = ~CLK_I;

    typedef struct {logic w; logic [7:0] a; logic [31:0] d;} req_t;
    req_t        exp_req[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  rx_q[$];
    logic [31:0] rsp_plan[$];
    int          n_chk = 0, n_pass = 0, err_seen = 0, exp_err = 0;
    logic        req_rand = 0, tx_rand = 0, rsp_rand = 0, req_man = 1, tx_man = 1;
    logic        re_s, rs_s;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic bad(input string nm);
        n_chk++;
        $display("FAIL %s: event not as required at %0t", nm, $time);
    endtask

    // RX FIFO, ready generators and read responder
    always begin
        @(negedge CLK_I);
        re_s = RE_O;
        rs_s = RSP_VALID_I && RSP_READY_O;
        @(posedge CLK_I);
        #1;
        if (!RST_I) begin
            if (re_s) void'(rx_q.pop_front());
            if (rs_s) void'(rsp_plan.pop_front());
        end
        REQ_READY_I = req_rand ? 1'($urandom_range(0, 1)) : req_man;
        TX_READY_I  = tx_rand ? 1'($urandom_range(0, 1)) : tx_man;
        RX_EMPTY_I  = rx_q.size() == 0;
        DREC_I      = rx_q.size() != 0 ? rx_q[0] : 8'h00;
        RSP_VALID_I = rsp_plan.size() != 0 && (rsp_rand ? 1'($urandom_range(0, 1)) : 1'b1);
        RSP_DATA_I  = rsp_plan.size() != 0 ? rsp_plan[0] : 32'h0;
    end

    // monitor: compare every presented output against the scoreboard
    always @(negedge CLK_I) begin
        if (ERR_O) err_seen++;
        if (REQ_VALID_O) begin
            if (exp_req.size() == 0) bad("req_unexpected");
            else begin
                chk("req_write", REQ_WRITE_O, exp_req[0].w);
                chk("req_addr", REQ_ADDR_O, exp_req[0].a);
                if (exp_req[0].w) chk("req_data", REQ_DATA_O, exp_req[0].d);
                if (REQ_READY_I) void'(exp_req.pop_front());
            end
        end
        if (WE_O) begin
            if (exp_tx.size() == 0) bad("tx_unexpected");
            else begin
                chk("tx_byte", DSEND_O, exp_tx[0]);
                void'(exp_tx.pop_front());
            end
        end
    end

    task automatic send(input logic [7:0] cmd, input logic [7:0] addr, input logic [31:0] d,
                        input logic [31:0] rsp, input int gap);
        logic [7:0] b [7];
        b[0] = HDR;
        b[1] = cmd;
        b[2] = addr;
        for (int i = 0; i < 4; i++) b[3+i] = d[8*i +: 8];
        if (cmd == WR || cmd == RD) exp_req.push_back('{cmd == WR, addr, d});
        else exp_err++;
        if (cmd == RD) begin
            rsp_plan.push_back(rsp);
            for (int i = 0; i < 4; i++) exp_tx.push_back(rsp[8*i +: 8]);
        end
        for (int i = 0; i < 7; i++) begin
            if (gap > 0) begin
                repeat (gap) @(posedge CLK_I);
                #2;
            end
            rx_q.push_back(b[i]);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!(rx_q.size() == 0 && exp_req.size() == 0 && exp_tx.size() == 0 &&
                 rsp_plan.size() == 0 && !BUSY_O) && n < 5000) begin
            @(negedge CLK_I);
            n++;
        end
        if (n >= 5000) bad({tag, "_idle_timeout"});
        repeat (3) @(negedge CLK_I);
        chk({tag, "_err_count"}, err_seen, exp_err);
        chk({tag, "_dsend_idle"}, DSEND_O, 0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge CLK_I);
        #2;
        RST_I = 1'b1;
        #1;
        chk({tag, "_rst_outputs"}, {RE_O, WE_O, DSEND_O, REQ_VALID_O, REQ_WRITE_O, REQ_ADDR_O,
                                    REQ_DATA_O, RSP_READY_O, ERR_O, BUSY_O}, 0);
        rx_q.delete();
        exp_req.delete();
        exp_tx.delete();
        rsp_plan.delete();
        @(posedge CLK_I);
        #2;
        RST_I = 1'b0;
    endtask

    initial begin
        int n, t;
        logic [7:0] c;
        repeat (2) @(posedge CLK_I);
        #2;
        chk("init_rst_outputs", {RE_O, WE_O, DSEND_O, REQ_VALID_O, REQ_WRITE_O, REQ_ADDR_O,
                                 REQ_DATA_O, RSP_READY_O, ERR_O, BUSY_O}, 0);
        RST_I = 1'b0;

        send(WR, 8'h10, 32'hDEADBEEF, 32'h0, 0);
        wait_idle("write");
        send(RD, 8'h20, 32'h0, 32'h12345678, 0);
        wait_idle("read");

        rx_q.push_back(8'h55);
        rx_q.push_back(8'hAA);
        send(8'h07, 8'h00, 32'h0, 32'h0, 0);
        wait_idle("badcmd");

        rx_q.push_back(HDR);
        rx_q.push_back(RD);
        exp_err++;
        n = 0;
        do begin
            @(negedge CLK_I);
            n++;
        end while (rx_q.size() != 0 && n < 100);
        t = 0;
        while (BUSY_O && t < 100) begin
            t++;
            @(negedge CLK_I);
        end
        chk("timeout_busy_cycles", t, 16);
        wait_idle("timeout");
        send(WR, 8'h33, 32'h01020304, 32'h0, 0);
        wait_idle("after_timeout");

        send(RD, 8'h66, 32'h0, 32'h89ABCDEF, 10);
        wait_idle("slow_bytes");

        req_man = 1'b0;
        tx_rand = 1'b1;
        send(RD, 8'h44, 32'h0BADF00D, 32'hCAFEF00D, 0);
        n = 0;
        while (!REQ_VALID_O && n < 100) begin
            @(negedge CLK_I);
            n++;
        end
        if (!REQ_VALID_O) bad("backpressure_no_req");
        repeat (5) @(posedge CLK_I);
        #2;
        req_man = 1'b1;
        wait_idle("backpressure");
        tx_rand = 1'b0;

        rx_q.push_back(HDR);
        rx_q.push_back(WR);
        rx_q.push_back(8'h10);
        rx_q.push_back(8'hAA);
        repeat (6) @(negedge CLK_I);
        do_reset("rx_data");
        send(WR, 8'h77, 32'h55AA33CC, 32'h0, 0);
        wait_idle("post_rx_reset");

        tx_man = 1'b0;
        send(RD, 8'h55, 32'h0, 32'hA1B2C3D4, 0);
        n = 0;
        do begin
            @(posedge CLK_I);
            #2;
            n++;
        end while ((rsp_plan.size() != 0 || exp_req.size() != 0) && n < 200);
        if (n >= 200) bad("midtx_no_response");
        tx_man = 1'b1;
        repeat (2) @(posedge CLK_I);
        #2;
        tx_man = 1'b0;
        repeat (2) @(posedge CLK_I);
        do_reset("tx");
        tx_man = 1'b1;
        send(RD, 8'h21, 32'h0, 32'h0F1E2D3C, 0);
        wait_idle("post_tx_reset");

        req_rand = 1'b1;
        tx_rand  = 1'b1;
        rsp_rand = 1'b1;
        for (int f = 0; f < 40; f++) begin
            repeat ($urandom_range(0, 2)) rx_q.push_back(8'($urandom_range(2, 255)));
            n = $urandom_range(0, 9);
            c = n < 4 ? WR : n < 8 ? RD : 8'($urandom_range(0, 255));
            if (n >= 8 && (c == WR || c == RD)) c = 8'hFF;
            send(c, 8'($urandom), $urandom, $urandom, 0);
        end
        wait_idle("random");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/uart_frame_decoder.md
# uart_frame_decoder

Command-frame decoder that sits directly downstream of the UART interface in the debug transport path. Drains received bytes from the UART RX FIFO, assembles fixed-length 7-byte command frames, and issues register read/write requests on a valid/ready request port. For read commands, collects the 32-bit response and pushes it back into the UART TX FIFO as four bytes. It also handles header hunting, unknown commands and inter-byte timeouts, so the downstream debug logic only ever sees well-formed requests.

## Interface
- `HEADER` — default 8'h01 — frame start byte.
- `CMD_READ` — default 8'h02 — read command code.
- `CMD_WRITE` — default 8'h03 — write command code.
- `TIMEOUT_CYCLES` — default 100000 — maximum idle clock cycles between bytes inside a frame; must be ≥ 2.

Ports:
- `CLK_I` — in — 1 — single clock.
- `RST_I` — in — 1 — reset, asynchronous, active-high.
- `RX_EMPTY_I` — in — 1 — UART RX FIFO empty.
- `RE_O` — out — 1 — RX FIFO read strobe.
- `DREC_I` — in — 8 — RX byte; valid in the same cycle as `RE_O`.
- `TX_READY_I` — in — 1 — UART TX FIFO not full.
- `WE_O` — out — 1 — TX FIFO write strobe.
- `DSEND_O` — out — 8 — TX byte; valid with `WE_O`.
- `REQ_VALID_O` — out — 1 — request valid.
- `REQ_READY_I` — in — 1 — request accepted.
- `REQ_WRITE_O` — out — 1 — 1 = write, 0 = read.
- `REQ_ADDR_O` — out — 8 — register address.
- `REQ_DATA_O` — out — 32 — write data; don't-care for reads.
- `RSP_VALID_I` — in — 1 — read response valid.
- `RSP_READY_O` — out — 1 — response accepted.
- `RSP_DATA_I` — in — 32 — read data.
- `ERR_O` — out — 1 — one-cycle pulse on a protocol error.
- `BUSY_O` — out — 1 — high in every state except IDLE.

## Operation
- **Frame format:** HEADER, CMD, ADDR, D0, D1, D2, D3. Data is little-endian (D0 = bits 7:0). Every command uses all 7 bytes.
- **States:** IDLE, RX_CMD, RX_ADDR, RX_DATA, REQ, WAIT_RSP, TX.
- **Reading bytes:**
  - `RE_O = !RX_EMPTY_I` in IDLE, RX_CMD, RX_ADDR and RX_DATA; otherwise 0. Combinational.
  - A byte is consumed on every cycle with `RE_O = 1`; `DREC_I` is sampled at that edge.
- **IDLE:** a byte equal to HEADER moves to RX_CMD. Any other byte is discarded silently, with no `ERR_O`.
- **RX_CMD:** store the command byte, go to RX_ADDR.
- **RX_ADDR:** store the address byte, go to RX_DATA with the byte counter at 0.
- **RX_DATA:**
  - Store the byte into bits [8k+7:8k] of the data register; k is a 2-bit counter.
  - When k = 3, decide:
    - CMD_WRITE or CMD_READ → REQ.
    - Any other CMD → IDLE and pulse `ERR_O`; no request is issued.
- **REQ:**
  - `REQ_VALID_O = 1`; `REQ_WRITE_O`, `REQ_ADDR_O` and `REQ_DATA_O` are held stable.
  - On `REQ_VALID_O && REQ_READY_I`: a write goes to IDLE, a read goes to WAIT_RSP.
- **WAIT_RSP:** `RSP_READY_O = 1`. On `RSP_VALID_I`, capture `RSP_DATA_I` and go to TX with the byte counter at 0.
- **TX:**
  - `WE_O = TX_READY_I`; `DSEND_O` = response byte k.
  - The counter advances on each cycle with `WE_O = 1`; after byte 3 is written, go to IDLE.
  - `DSEND_O` is 0 outside TX.
- **Timeout:**
  - The counter runs only in RX_CMD, RX_ADDR and RX_DATA; it clears on every consumed byte and on entry to those states.
  - When it reaches TIMEOUT_CYCLES−1 with no byte consumed that cycle: go to IDLE and pulse `ERR_O`. The partial frame is dropped.
  - Width is $clog2(TIMEOUT_CYCLES).
  - REQ, WAIT_RSP and TX never time out.
- **Reset:** `RST_I` asserted at any time, including mid-frame or mid-TX, forces IDLE immediately. All registers clear; an in-flight request or partial transmission is abandoned.

## Timing
- Reset values: `RE_O` = 0, `WE_O` = 0, `DSEND_O` = 0, `REQ_VALID_O` = 0, `REQ_WRITE_O` = 0, `REQ_ADDR_O` = 0, `REQ_DATA_O` = 0, `RSP_READY_O` = 0, `ERR_O` = 0, `BUSY_O` = 0.
- Maximum throughput: one byte per cycle. With a non-empty FIFO, a frame is absorbed in 7 consecutive cycles.
- Request latency: D3 is consumed at edge n; `REQ_VALID_O` is high in cycle n+1.
- `REQ_READY_I` high in the first REQ cycle gives a 1-cycle REQ state.
- Response: handshake at edge m; first `WE_O` is possible in cycle m+1. Four bytes take 4 cycles when `TX_READY_I` stays high.
- `TX_READY_I` low stalls TX indefinitely; no byte is lost or duplicated.
- `ERR_O` is asserted in the cycle after the offending edge, for exactly 1 cycle.
- Bytes arriving during REQ, WAIT_RSP or TX stay in the RX FIFO; they are not read until IDLE.

## Test plan
- **Write frame:** bytes 01 03 10 EF BE AD DE with `REQ_READY_I` = 1 → one request with `REQ_WRITE_O` = 1, `REQ_ADDR_O` = 8'h10, `REQ_DATA_O` = 32'hDEADBEEF; no `WE_O`; back to IDLE.
- **Read frame:** 01 02 20 00 00 00 00, response 32'h12345678 → request with `REQ_WRITE_O` = 0, `REQ_ADDR_O` = 8'h20; TX bytes 78 56 34 12 in order.
- **Garbage and bad command:** 55 AA, then 01 07 00 00 00 00 00 → leading bytes discarded without error; `ERR_O` pulses once; no `REQ_VALID_O`.
- **Timeout:** `TIMEOUT_CYCLES` = 16; send 01 02 then stall 16 cycles → `ERR_O` pulse, return to IDLE; a following valid frame is decoded correctly.
- **Back-pressure:** read frame with `REQ_READY_I` held low 5 cycles and `TX_READY_I` toggling → request fields stable throughout; exactly 4 TX bytes, correct order.
- **Mid-operation reset:** assert `RST_I` during RX_DATA and again during TX → all outputs return to reset values immediately; the next frame decodes normally.
